// File: rtl/mod_n_updown_counter_if.sv
// Bundle of control inputs and status outputs of the programmable mod-N counter.
// The master side drives requests; the slave side is the counter itself.
interface mod_n_updown_counter_if #(
    parameter int WIDTH  = 2,
    parameter int WRAP_W = 8
);
    logic              en;
    logic              up_dn;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              mod_we;
    logic [WIDTH:0]    mod_val;
    logic [WIDTH-1:0]  q;
    logic [WIDTH:0]    mod_q;
    logic              tc;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              err;

    modport master (
        output en, up_dn, load, load_val, mod_we, mod_val,
        input  q, mod_q, tc, wrap_cnt, err
    );

    modport slave (
        input  en, up_dn, load, load_val, mod_we, mod_val,
        output q, mod_q, tc, wrap_cnt, err
    );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Synchronous mod-N up/down counter with run-time modulus, parallel load, cascade carry
// and saturating wrap counter. Request priority per edge: mod_we > load > en.
module mod_n_updown_counter #(
    parameter int WIDTH       = 2,
    parameter int DEFAULT_MOD = 3,
    parameter int WRAP_W      = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    mod_n_updown_counter_if.slave bus
);
    localparam logic [WIDTH:0]    MAX_MOD = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0]    MIN_MOD = (WIDTH+1)'(2);
    localparam logic [WIDTH:0]    RST_MOD = (WIDTH+1)'(DEFAULT_MOD);
    localparam logic [WIDTH:0]    ONE_M   = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0]  ONE_Q   = WIDTH'(1);
    localparam logic [WRAP_W-1:0] ONE_W   = WRAP_W'(1);

    logic [WIDTH-1:0]  q_reg, q_next;
    logic [WIDTH:0]    mod_q_reg, mod_q_next;
    logic [WRAP_W-1:0] wrap_cnt_reg, wrap_cnt_next;
    logic              err_reg, err_next;

    logic [WIDTH:0]    top_val;
    logic              at_top, at_zero, wrap_hit, mod_ok, load_ok;

    // Comparisons are done one bit wider than q so mod_q == 2^WIDTH is representable.
    assign top_val  = mod_q_reg - ONE_M;
    assign at_top   = ({1'b0, q_reg} == top_val);
    assign at_zero  = (q_reg == '0);
    assign wrap_hit = bus.en & ~bus.mod_we & ~bus.load & (bus.up_dn ? at_top : at_zero);
    assign mod_ok   = (bus.mod_val >= MIN_MOD) && (bus.mod_val <= MAX_MOD);
    assign load_ok  = ({1'b0, bus.load_val} < mod_q_reg);

    // Zero-latency carry so a cascaded stage advances on the same edge as this wrap.
    assign bus.tc       = clr & wrap_hit;
    assign bus.q        = q_reg;
    assign bus.mod_q    = mod_q_reg;
    assign bus.wrap_cnt = wrap_cnt_reg;
    assign bus.err      = err_reg;

    always_comb begin
        q_next        = q_reg;
        mod_q_next    = mod_q_reg;
        wrap_cnt_next = wrap_cnt_reg;
        err_next      = err_reg;
        if (bus.mod_we) begin
            if (mod_ok) begin
                mod_q_next = bus.mod_val;
                if ({1'b0, q_reg} >= bus.mod_val) begin
                    q_next = '0;
                end
            end else begin
                err_next = 1'b1;
            end
        end else if (bus.load) begin
            if (load_ok) begin
                q_next = bus.load_val;
            end else begin
                err_next = 1'b1;
            end
        end else if (bus.en) begin
            if (wrap_hit) begin
                q_next = bus.up_dn ? '0 : top_val[WIDTH-1:0];
                if (wrap_cnt_reg != '1) begin
                    wrap_cnt_next = wrap_cnt_reg + ONE_W;
                end
            end else begin
                q_next = bus.up_dn ? (q_reg + ONE_Q) : (q_reg - ONE_Q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            q_reg        <= '0;
            mod_q_reg    <= RST_MOD;
            wrap_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            q_reg        <= q_next;
            mod_q_reg    <= mod_q_next;
            wrap_cnt_reg <= wrap_cnt_next;
            err_reg      <= err_next;
        end
    end
endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench for mod_n_updown_counter: single counter plus a two-stage tc->en cascade.
module tb_mod_n_updown_counter;
    logic clk = 1'b0;
    logic clr;
    logic clr_c;
    int   checks = 0;
    int   errors = 0;

    int t1_q [7] = '{1, 2, 0, 1, 2, 0, 1};
    int t1_tc[7] = '{0, 0, 1, 0, 0, 1, 0};
    int t2_q [4] = '{2, 1, 0, 2};
    int t2_tc[4] = '{1, 0, 0, 1};
    int t3_q [4] = '{1, 2, 3, 0};
    int t3_tc[4] = '{0, 0, 0, 1};

    always #5 clk = ~clk;

    mod_n_updown_counter_if #(.WIDTH(2), .WRAP_W(8)) b0 ();
    mod_n_updown_counter_if #(.WIDTH(2), .WRAP_W(2)) c0 ();
    mod_n_updown_counter_if #(.WIDTH(2), .WRAP_W(2)) c1 ();

    mod_n_updown_counter #(.WIDTH(2), .DEFAULT_MOD(3), .WRAP_W(8)) u0 (
        .clk(clk), .clr(clr), .bus(b0)
    );
    mod_n_updown_counter #(.WIDTH(2), .DEFAULT_MOD(3), .WRAP_W(2)) u_lo (
        .clk(clk), .clr(clr_c), .bus(c0)
    );
    mod_n_updown_counter #(.WIDTH(2), .DEFAULT_MOD(3), .WRAP_W(2)) u_hi (
        .clk(clk), .clr(clr_c), .bus(c1)
    );

    assign c1.en = c0.tc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t q=%0d mod_q=%0d wrap=%0d err=%b | lo=%0d hi=%0d",
                 $time, b0.q, b0.mod_q, b0.wrap_cnt, b0.err, c0.q, c1.q);
    endtask

    initial begin
        clr = 1'b0;
        clr_c = 1'b0;
        b0.en = 0; b0.up_dn = 1; b0.load = 0; b0.load_val = 0; b0.mod_we = 0; b0.mod_val = 0;
        c0.en = 0; c0.up_dn = 1; c0.load = 0; c0.load_val = 0; c0.mod_we = 0; c0.mod_val = 0;
        c1.up_dn = 1; c1.load = 0; c1.load_val = 0; c1.mod_we = 0; c1.mod_val = 0;
        tick();
        tick();

        // Reset state; tc must stay low while clr is low even at a down-wrap point
        b0.en = 1; b0.up_dn = 0;
        #1;
        chk("rst_tc", b0.tc, 0);
        tick();
        chk("rst_q", b0.q, 0);
        chk("rst_mod_q", b0.mod_q, 3);
        chk("rst_wrap", b0.wrap_cnt, 0);
        chk("rst_err", b0.err, 0);

        // 1: up count mod 3
        clr = 1; b0.up_dn = 1; b0.en = 1;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("t1_tc", b0.tc, t1_tc[i]);
            tick();
            chk("t1_q", b0.q, t1_q[i]);
        end
        chk("t1_wrap", b0.wrap_cnt, 2);

        // 2: down count from 0
        clr = 0;
        tick();
        clr = 1;
        chk("t2_q0", b0.q, 0);
        chk("t2_wrap0", b0.wrap_cnt, 0);
        b0.up_dn = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_tc", b0.tc, t2_tc[i]);
            tick();
            chk("t2_q", b0.q, t2_q[i]);
        end
        chk("t2_wrap", b0.wrap_cnt, 2);

        // 3: modulus writes (q=2 now); en/up asserted but mod_we wins
        b0.up_dn = 1; b0.en = 1; b0.mod_we = 1; b0.mod_val = 2;
        #1;
        chk("t3_tc_masked", b0.tc, 0);
        tick();
        chk("t3_q_clip", b0.q, 0);
        chk("t3_mod2", b0.mod_q, 2);
        chk("t3_err0", b0.err, 0);
        b0.mod_val = 1;
        tick();
        chk("t3_mod_low", b0.mod_q, 2);
        chk("t3_err_low", b0.err, 1);
        b0.mod_val = 5;
        tick();
        chk("t3_mod_high", b0.mod_q, 2);
        b0.mod_val = 4;
        tick();
        chk("t3_mod4", b0.mod_q, 4);
        chk("t3_q_hold", b0.q, 0);
        chk("t3_wrap_hold", b0.wrap_cnt, 2);
        b0.mod_we = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_tc", b0.tc, t3_tc[i]);
            tick();
            chk("t3_q", b0.q, t3_q[i]);
        end
        chk("t3_wrap", b0.wrap_cnt, 3);
        tick();
        b0.mod_we = 1; b0.mod_val = 3;
        tick();
        chk("t3_q_keep", b0.q, 1);
        chk("t3_mod3", b0.mod_q, 3);
        b0.mod_we = 0;

        // 4: parallel load
        clr = 0; b0.en = 0;
        tick();
        clr = 1;
        chk("t4_err_clr", b0.err, 0);
        b0.en = 1;
        tick();
        tick();
        chk("t4_q2", b0.q, 2);
        b0.load = 1; b0.load_val = 1;
        #1;
        chk("t4_tc_masked", b0.tc, 0);
        tick();
        chk("t4_load", b0.q, 1);
        chk("t4_wrap", b0.wrap_cnt, 0);
        b0.load_val = 3;
        tick();
        chk("t4_bad_q", b0.q, 1);
        chk("t4_bad_err", b0.err, 1);
        b0.load = 0; b0.en = 0;
        tick();
        tick();
        tick();
        chk("t4_idle_q", b0.q, 1);
        chk("t4_sticky", b0.err, 1);
        b0.load = 1; b0.load_val = 0;
        tick();
        chk("t4_load0", b0.q, 0);
        chk("t4_sticky2", b0.err, 1);
        b0.load = 0;

        // 5: mid-count reset
        b0.en = 1;
        tick();
        tick();
        tick();
        chk("t5_q", b0.q, 0);
        chk("t5_wrap", b0.wrap_cnt, 1);
        clr = 0;
        #3;
        clr = 1;
        tick();
        chk("t5_glitch_q", b0.q, 1);
        chk("t5_glitch_wrap", b0.wrap_cnt, 1);
        clr = 0; b0.load = 1; b0.load_val = 2; b0.mod_we = 1; b0.mod_val = 4;
        tick();
        chk("t5_rst_q", b0.q, 0);
        chk("t5_rst_mod", b0.mod_q, 3);
        chk("t5_rst_wrap", b0.wrap_cnt, 0);
        chk("t5_rst_err", b0.err, 0);
        clr = 1; b0.load = 0; b0.mod_we = 0; b0.en = 0;

        // 6a: two-digit base-3 cascade
        tick();
        clr_c = 1; c0.en = 1;
        for (int k = 1; k <= 9; k++) begin
            #1;
            chk("t6_tc", c0.tc, ((k - 1) % 3 == 2) ? 1 : 0);
            tick();
            chk("t6_lo", c0.q, (k % 9) % 3);
            chk("t6_hi", c1.q, (k % 9) / 3);
        end
        chk("t6_lo_wrap", c0.wrap_cnt, 3);
        chk("t6_hi_wrap", c1.wrap_cnt, 1);

        // 6b: saturating wrap counter, mod 2
        clr_c = 0; c0.en = 0;
        tick();
        clr_c = 1; c0.mod_we = 1; c0.mod_val = 2;
        tick();
        chk("t6_mod2", c0.mod_q, 2);
        c0.mod_we = 0; c0.en = 1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("t6_sat", c0.wrap_cnt, (k / 2 > 3) ? 3 : k / 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
